// File: rtl/data_bus_bridge.sv
// data_bus_bridge: memory stage behind the RV32I M stage.
// Word-addressed data RAM plus MMIO: LEDs, synchronized switches, cycle timer
// and a byte TX FIFO with a valid/ready drain port. ReadDataM is combinational.
// Optional build macro: DATA_BUS_TIMER_EN adds the counter/compare/flag timer;
// without it the timer registers read 0, ignore writes and timer_irq is 0.
module data_bus_bridge #(
  parameter int RAM_WORDS  = 256,
  parameter int FIFO_DEPTH = 4,
  parameter int GPIO_W     = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              MemWriteM,
  input  logic [31:0]       ALUResultM,
  input  logic [31:0]       WriteDataM,
  output logic [31:0]       ReadDataM,
  input  logic [GPIO_W-1:0] switches_i,
  output logic [GPIO_W-1:0] leds_o,
  output logic              tx_valid,
  output logic [7:0]        tx_data,
  input  logic              tx_ready,
  output logic              timer_irq
);
  localparam int AW = $clog2(RAM_WORDS);
  localparam int FW = $clog2(FIFO_DEPTH);
  localparam logic [FW:0] FULL_CNT = (FW+1)'(FIFO_DEPTH);

  typedef struct packed {
    logic        we;
    logic [29:0] wordAddr;
    logic [31:0] wdata;
  } busReqT;

  typedef enum logic [2:0] {
    SEL_NONE, SEL_RAM, SEL_LED, SEL_SW, SEL_CNT, SEL_CMP, SEL_STAT, SEL_TX
  } selT;

  busReqT req;
  selT    sel;
  logic   unusedByteOffset;

  assign req = '{we: MemWriteM, wordAddr: ALUResultM[31:2], wdata: WriteDataM};
  // Accesses are word-only; the byte offset is deliberately dropped.
  assign unusedByteOffset = ^ALUResultM[1:0];

  // Decode the word address; RAM occupies the bottom of the map.
  always_comb begin
    sel = SEL_NONE;
    if (req.wordAddr[29:AW] == '0) begin
      sel = SEL_RAM;
    end else begin
      case (req.wordAddr)
        30'h800: sel = SEL_LED;
        30'h801: sel = SEL_SW;
        30'h802: sel = SEL_CNT;
        30'h803: sel = SEL_CMP;
        30'h804: sel = SEL_STAT;
        30'h805: sel = SEL_TX;
        default: sel = SEL_NONE;
      endcase
    end
  end

  logic ramWe, ledWe, statWe, pushReq;
  assign ramWe   = req.we && (sel == SEL_RAM);
  assign ledWe   = req.we && (sel == SEL_LED);
  assign statWe  = req.we && (sel == SEL_STAT);
  assign pushReq = req.we && (sel == SEL_TX);

  // ---------------- data RAM ----------------
  logic [31:0]   ram [RAM_WORDS];
  logic [AW-1:0] ramIdx;
  assign ramIdx = req.wordAddr[AW-1:0];

  // RAM write port; contents survive reset on purpose.
  always_ff @(posedge clk) begin
    if (ramWe) ram[ramIdx] <= req.wdata;
  end

  // ---------------- GPIO ----------------
  logic [GPIO_W-1:0] swMeta, swSync;

  // Two-flop synchronizer for the asynchronous board switches.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      swMeta <= '0;
      swSync <= '0;
    end else begin
      swMeta <= switches_i;
      swSync <= swMeta;
    end
  end

  // LED output register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)     leds_o <= '0;
    else if (ledWe) leds_o <= req.wdata[GPIO_W-1:0];
  end

  // ---------------- TX FIFO ----------------
  logic [7:0]    fifoMem [FIFO_DEPTH];
  logic [FW-1:0] rdPtr, wrPtr;
  logic [FW:0]   count;
  logic          full, empty, pop, push, ovf;

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);
  assign pop   = !empty && tx_ready;
  // When full, a same-cycle pop frees the slot the push lands in.
  assign push  = pushReq && (!full || pop);

  // FIFO storage; the output is gated by empty so contents need no reset.
  always_ff @(posedge clk) begin
    if (push) fifoMem[wrPtr] <= req.wdata[7:0];
  end

  // Pointers and occupancy; depth is a power of two so pointers wrap naturally.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
    end else begin
      if (pop)  rdPtr <= rdPtr + FW'(1);
      if (push) wrPtr <= wrPtr + FW'(1);
      case ({push, pop})
        2'b10:   count <= count + (FW+1)'(1);
        2'b01:   count <= count - (FW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Sticky overflow: a dropped push sets it, a write-1 to status bit 3 clears it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                             ovf <= 1'b0;
    else if (pushReq && full && !pop)       ovf <= 1'b1;
    else if (statWe && req.wdata[3])        ovf <= 1'b0;
  end

  assign tx_valid = !empty;
  assign tx_data  = empty ? 8'h00 : fifoMem[rdPtr];

  // ---------------- timer ----------------
  logic [31:0] cntRd, cmpRd;
  logic        flag;

`ifdef DATA_BUS_TIMER_EN
  logic [31:0] cnt, cmp;
  logic        cntWe, cmpWe;
  assign cntWe = req.we && (sel == SEL_CNT);
  assign cmpWe = req.we && (sel == SEL_CMP);

  // Free-running counter; any write to it forces 0 and beats the increment.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)     cnt <= '0;
    else if (cntWe) cnt <= '0;
    else            cnt <= cnt + 32'd1;
  end

  // Compare register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)     cmp <= '0;
    else if (cmpWe) cmp <= req.wdata;
  end

  // Sticky match flag; a match in the same cycle as a clear keeps it set.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                              flag <= 1'b0;
    else if ((cnt == cmp) && (cmp != '0))    flag <= 1'b1;
    else if (statWe && req.wdata[0])         flag <= 1'b0;
  end

  assign cntRd = cnt;
  assign cmpRd = cmp;
`else
  assign cntRd = '0;
  assign cmpRd = '0;
  assign flag  = 1'b0;
`endif

  assign timer_irq = flag;

  // ---------------- load mux ----------------
  // Same-cycle load data; unmapped and write-only locations read 0.
  always_comb begin
    ReadDataM = '0;
    case (sel)
      SEL_RAM:  ReadDataM = ram[ramIdx];
      SEL_LED:  ReadDataM = 32'(leds_o);
      SEL_SW:   ReadDataM = 32'(swSync);
      SEL_CNT:  ReadDataM = cntRd;
      SEL_CMP:  ReadDataM = cmpRd;
      SEL_STAT: ReadDataM = {28'd0, ovf, empty, full, flag};
      default:  ReadDataM = '0;
    endcase
  end

endmodule

// File: doc/data_bus_bridge.md
# data_bus_bridge

Memory-side stage directly downstream of the pipelined RV32I core's M stage. It consumes `MemWriteM`, `ALUResultM` and `WriteDataM`, and returns `ReadDataM` in the same cycle. It decodes the address into word-addressed data RAM plus a small MMIO block: GPIO, a cycle timer and a buffered byte-transmit FIFO with a valid/ready output.

## Interface
- `RAM_WORDS`, 256, data RAM depth in 32-bit words (power of two, ≤ 1024)
- `FIFO_DEPTH`, 4, TX byte FIFO entries (power of two, ≥ 2)
- `GPIO_W`, 16, width of LED output and switch input
- `clk` in 1: single clock, all state on rising edge
- `reset` in 1: asynchronous, active-low; asserting low clears all registers immediately
- `MemWriteM` in 1: store strobe from core M stage
- `ALUResultM` in 32: byte address from core M stage
- `WriteDataM` in 32: store data
- `ReadDataM` out 32: combinational load data for the current `ALUResultM`
- `switches_i` in GPIO_W: asynchronous board inputs
- `leds_o` out GPIO_W: GPIO output register
- `tx_valid` out 1: FIFO head available
- `tx_data` out 8: FIFO head byte
- `tx_ready` in 1: sink accepts head when `tx_valid` & `tx_ready`
- `timer_irq` out 1: equals sticky timer flag

## Operation
- Address map (`ALUResultM[1:0]` ignored, word access only):
  - 0x0000_0000 to 4·RAM_WORDS−1: RAM, index `ALUResultM[log2(RAM_WORDS)+1:2]`
  - 0x2000: LED register (R/W)
  - 0x2004: synchronized switches (RO, zero-extended)
  - 0x2008: cycle counter (R; any write clears it to 0)
  - 0x200C: compare register (R/W)
  - 0x2010: status, bits [0] timer flag, [1] FIFO full, [2] FIFO empty, [3] overflow; write 1 clears bits 0 and 3, other bits RO
  - 0x2014: TX push (W, `WriteDataM[7:0]`); reads return 0
- Unmapped reads return 0. Unmapped writes are ignored.
- RAM: combinational read, synchronous write on `MemWriteM`. RAM contents are not reset.
- Switches pass through a 2-flop synchronizer, reset value 0.
- Counter increments every cycle and wraps from 0xFFFF_FFFF to 0.
- Timer flag sets when counter == compare and compare ≠ 0. The flag is sticky.
- FIFO push on a write to 0x2014:
  - When full and no pop occurs in the same cycle, the byte is dropped and overflow sets.
  - A push and a pop in the same cycle while full are both accepted; the count is unchanged.
  - `tx_valid` = !empty. `tx_data` = head, held stable until popped.
- Reset values:
  - `ReadDataM` is a function of its inputs only.
  - `leds_o`, counter, compare, status bits, FIFO pointers and count all reset to 0.
  - `tx_valid`=0, `tx_data`=0, `timer_irq`=0.
- Reset asserted mid-operation discards FIFO contents and any pending handshake. RAM retains its contents.

## Timing
- Load latency 0: `ReadDataM` is valid in the same cycle as `ALUResultM`, ready for the core's M→W register.
- Store effect is visible to a read in the cycle after the `MemWriteM` edge.
- Counter write vs. increment in the same cycle: the write wins, and the counter reads 0 next cycle.
- Flag set condition and write-1-clear in the same cycle: set wins.
- Status full/empty reflect the registered count (pre-edge state).
- Switch change reaches 0x2004 two cycles after the edge at which it is stable.
- `tx_valid` rises in the cycle after the push edge. A pop removes the head at the edge where `tx_valid` & `tx_ready`.

## Configuration
- `DATA_BUS_TIMER_EN` defined:
  - Counter, compare and timer flag are implemented as above.
- `DATA_BUS_TIMER_EN` undefined:
  - 0x2008 and 0x200C read 0, and writes to them are ignored.
  - Status bit 0 reads 0.
  - `timer_irq` is tied 0.
  - No counter flops are synthesized.

## Test plan
- RAM store/load: write 0xDEADBEEF to 0x0000_0010, then read 0x10 → 0xDEADBEEF. Read 0x3000 → 0. After reset pulse, 0x2000 reads 0.
- GPIO: write 0x0000_A5A5 to 0x2000 → `leds_o`=0xA5A5 next cycle. Set switches to 0x1234 → 0x2004 reads 0x0000_1234 two cycles later.
- FIFO: with `tx_ready`=0, push 0x41,0x42,0x43,0x44 → status full=1. Push 0x45 → dropped, overflow=1. Raise `tx_ready` → bytes 0x41..0x44 emitted in order, one per cycle, then empty=1.
- Full push+pop: FIFO full, push 0x55 and `tx_ready`=1 in the same cycle → head popped, 0x55 enqueued at tail, full stays 1.
- Timer (`DATA_BUS_TIMER_EN`): write compare 20, clear counter → `timer_irq`=1 after counter reaches 20. Write 0x1 to 0x2010 → flag clears. Compare 0 never sets the flag.
- Async reset asserted low mid-transmit with 3 bytes queued → `tx_valid`=0 immediately, FIFO empty after release.
